hist_lut_builder: RTL and testbench

Histogram-equalization LUT builder for the thermal video path. On a `start` pulse, it scans every bin of the frame histogram RAM in order and applies an optional clip limit. It accumulates the cumulative distribution, scales it to the 8-bit output range with a software-supplied coefficient, and writes one entry per bin into the remap LUT RAM port (`hist_lut_ram_we/addr/din`) of the AXI4-Stream histogram remapper. The sweep runs during vertical blanking, between the histogram collector finishing frame N and the remapper starting frame N+1.

---
 rtl/hist_eq_pkg.sv | 33 +++
 rtl/hist_lut_builder_if.sv | 33 +++
 rtl/hist_cdf_scaler.sv | 90 +++++++++
 rtl/hist_lut_builder.sv | 112 +++++++++++
 tb/tb_hist_lut_builder.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/hist_eq_pkg.sv
// Shared definitions for the histogram-equalization LUT builder.
//   - default widths and RAM latency
//   - sweep FSM state enumeration
//   - drain length and whole-sweep length helpers
package hist_eq_pkg;

   localparam int ADDR_WIDTH_DEF  = 14;
   localparam int BIN_WIDTH_DEF   = 20;
   localparam int LUT_WIDTH_DEF   = 8;
   localparam int COEF_WIDTH_DEF  = 24;
   localparam int FRAC_BITS_DEF   = 24;
   localparam int RAM_LATENCY_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } sweep_state_t;

   // Cycles from the last read issue until the last LUT write has landed.
   function automatic int drain_cycles(input int ram_latency);
      return ram_latency + 3;
   endfunction

   // Cycles from the start pulse to the done pulse, inclusive of done.
   function automatic int sweep_cycles(input int addr_width, input int ram_latency);
      return (1 << addr_width) + ram_latency + 4;
   endfunction

   localparam int SWEEP_CYCLES_DEF = sweep_cycles(ADDR_WIDTH_DEF, RAM_LATENCY_DEF);

endpackage

// File: rtl/hist_lut_builder_if.sv
// Control, histogram RAM read port and LUT RAM write port of the LUT builder.
//   master : the builder (drives busy/done, RAM read address, LUT writes)
//   slave  : the environment (drives start/coef/clip, returns RAM read data)
interface hist_lut_builder_if import hist_eq_pkg::*; #(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int BIN_WIDTH  = BIN_WIDTH_DEF,
   parameter int LUT_WIDTH  = LUT_WIDTH_DEF,
   parameter int COEF_WIDTH = COEF_WIDTH_DEF
);
   logic                  start;
   logic [COEF_WIDTH-1:0] norm_coef;
   logic [BIN_WIDTH-1:0]  clip_limit;
   logic                  busy;
   logic                  done;
   logic                  hist_ram_en;
   logic [ADDR_WIDTH-1:0] hist_ram_addr;
   logic [BIN_WIDTH-1:0]  hist_ram_dout;
   logic                  hist_lut_ram_we;
   logic [ADDR_WIDTH-1:0] hist_lut_ram_addr;
   logic [LUT_WIDTH-1:0]  hist_lut_ram_din;

   modport master (
      input  start, norm_coef, clip_limit, hist_ram_dout,
      output busy, done, hist_ram_en, hist_ram_addr,
             hist_lut_ram_we, hist_lut_ram_addr, hist_lut_ram_din
   );

   modport slave (
      output start, norm_coef, clip_limit, hist_ram_dout,
      input  busy, done, hist_ram_en, hist_ram_addr,
             hist_lut_ram_we, hist_lut_ram_addr, hist_lut_ram_din
   );
endinterface

// File: rtl/hist_cdf_scaler.sv
// Clip, CDF accumulate, scale and saturate; one bin per cycle.
//   clk, rst_n      : clock, async active-low reset
//   clear           : zero the CDF before a sweep
//   rd_en, rd_addr  : read issue, delayed alongside the RAM read latency
//   coef, clip      : latched scale coefficient and clip limit (0 = no clip)
//   ram_dout        : histogram RAM read data, valid RAM_LATENCY after rd_en
//   lut_we/addr/din : LUT write, RAM_LATENCY+3 cycles after the read issue
module hist_cdf_scaler import hist_eq_pkg::*; #(
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int BIN_WIDTH   = BIN_WIDTH_DEF,
   parameter int LUT_WIDTH   = LUT_WIDTH_DEF,
   parameter int COEF_WIDTH  = COEF_WIDTH_DEF,
   parameter int FRAC_BITS   = FRAC_BITS_DEF,
   parameter int RAM_LATENCY = RAM_LATENCY_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [COEF_WIDTH-1:0] coef,
   input  logic [BIN_WIDTH-1:0]  clip,
   input  logic [BIN_WIDTH-1:0]  ram_dout,
   output logic                  lut_we,
   output logic [ADDR_WIDTH-1:0] lut_addr,
   output logic [LUT_WIDTH-1:0]  lut_din
);
   localparam int PROD_W = BIN_WIDTH + COEF_WIDTH;

   logic [RAM_LATENCY-1:0] v_dl;
   logic [ADDR_WIDTH-1:0]  a_dl [RAM_LATENCY];
   logic [BIN_WIDTH-1:0]   bin;
   logic [BIN_WIDTH:0]     cdf_sum;
   logic [BIN_WIDTH-1:0]   cdf;
   logic                   v_c, v_m;
   logic [ADDR_WIDTH-1:0]  a_c, a_m;
   logic [PROD_W-1:0]      prod;
   logic [PROD_W-1:0]      q;
   logic                   q_sat;

   always_comb begin
      bin = ram_dout;
      if ((clip != '0) && (ram_dout > clip)) bin = clip;
   end

   assign cdf_sum = {1'b0, cdf} + {1'b0, bin};
   assign q       = prod >> FRAC_BITS;
   assign q_sat   = |q[PROD_W-1:LUT_WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_dl     <= '0;
         for (int i = 0; i < RAM_LATENCY; i++) a_dl[i] <= '0;
         cdf      <= '0;
         v_c      <= 1'b0;
         a_c      <= '0;
         prod     <= '0;
         v_m      <= 1'b0;
         a_m      <= '0;
         lut_we   <= 1'b0;
         lut_addr <= '0;
         lut_din  <= '0;
      end else begin
         // valid/address delay line matching the RAM read latency
         v_dl[0] <= rd_en;
         a_dl[0] <= rd_addr;
         for (int i = 1; i < RAM_LATENCY; i++) begin
            v_dl[i] <= v_dl[i-1];
            a_dl[i] <= a_dl[i-1];
         end
         // stage C: saturating accumulate
         if (clear)
            cdf <= '0;
         else if (v_dl[RAM_LATENCY-1])
            cdf <= cdf_sum[BIN_WIDTH] ? '1 : cdf_sum[BIN_WIDTH-1:0];
         v_c <= v_dl[RAM_LATENCY-1];
         a_c <= a_dl[RAM_LATENCY-1];
         // stage M
         prod <= PROD_W'(cdf) * PROD_W'(coef);
         v_m  <= v_c;
         a_m  <= a_c;
         // stage W
         lut_we <= v_m;
         if (v_m) begin
            lut_addr <= a_m;
            lut_din  <= q_sat ? '1 : q[LUT_WIDTH-1:0];
         end
      end
   end
endmodule

// File: rtl/hist_lut_builder.sv
// Histogram-equalization LUT builder top: sweep FSM, read counter, input latches.
//   axis_aclk    : clock
//   axis_aresetn : async active-low reset
//   bus          : control + histogram RAM read + LUT RAM write (master side)
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | waiting for start; start latches coef/clip, clears CDF
// ST_READ  | one histogram read per cycle, address 0..2^ADDR_WIDTH-1
// ST_DRAIN | reads done, pipeline still emitting LUT writes
// ST_DONE  | one-cycle done pulse
module hist_lut_builder import hist_eq_pkg::*; #(
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int BIN_WIDTH   = BIN_WIDTH_DEF,
   parameter int LUT_WIDTH   = LUT_WIDTH_DEF,
   parameter int COEF_WIDTH  = COEF_WIDTH_DEF,
   parameter int FRAC_BITS   = FRAC_BITS_DEF,
   parameter int RAM_LATENCY = RAM_LATENCY_DEF
) (
   input  logic              axis_aclk,
   input  logic              axis_aresetn,
   hist_lut_builder_if.master bus
);
   localparam int DRAIN_CYC = drain_cycles(RAM_LATENCY);
   localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);
   localparam logic [DRAIN_W-1:0]    DRAIN_LOAD = DRAIN_W'(DRAIN_CYC - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;

   sweep_state_t          state, state_nxt;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DRAIN_W-1:0]    drain_cnt;
   logic [COEF_WIDTH-1:0] coef_q;
   logic [BIN_WIDTH-1:0]  clip_q;
   logic                  start_ok;
   logic                  busy_c, done_c, en_c;

   assign start_ok = (state == ST_IDLE) && bus.start;

   always_comb begin
      state_nxt = state;
      busy_c    = 1'b0;
      done_c    = 1'b0;
      en_c      = 1'b0;
      case (state)
         ST_IDLE: if (bus.start) state_nxt = ST_READ;
         ST_READ: begin
            busy_c = 1'b1;
            en_c   = 1'b1;
            if (rd_addr == LAST_ADDR) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy_c = 1'b1;
            if (drain_cnt == '0) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done_c    = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         state     <= ST_IDLE;
         rd_addr   <= '0;
         drain_cnt <= '0;
         coef_q    <= '0;
         clip_q    <= '0;
      end else begin
         state <= state_nxt;
         if (start_ok) begin
            rd_addr <= '0;
            coef_q  <= bus.norm_coef;
            clip_q  <= bus.clip_limit;
         end else if ((state == ST_READ) && (rd_addr != LAST_ADDR)) begin
            rd_addr <= rd_addr + 1'b1;
         end
         // drain timer is reloaded every READ cycle and counts down in DRAIN
         if (state == ST_READ)
            drain_cnt <= DRAIN_LOAD;
         else if ((state == ST_DRAIN) && (drain_cnt != '0))
            drain_cnt <= drain_cnt - 1'b1;
      end
   end

   assign bus.busy          = busy_c;
   assign bus.done          = done_c;
   assign bus.hist_ram_en   = en_c;
   assign bus.hist_ram_addr = rd_addr;

   hist_cdf_scaler #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BIN_WIDTH  (BIN_WIDTH),
      .LUT_WIDTH  (LUT_WIDTH),
      .COEF_WIDTH (COEF_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .RAM_LATENCY(RAM_LATENCY)
   ) u_scaler (
      .clk     (axis_aclk),
      .rst_n   (axis_aresetn),
      .clear   (start_ok),
      .rd_en   (en_c),
      .rd_addr (rd_addr),
      .coef    (coef_q),
      .clip    (clip_q),
      .ram_dout(bus.hist_ram_dout),
      .lut_we  (bus.hist_lut_ram_we),
      .lut_addr(bus.hist_lut_ram_addr),
      .lut_din (bus.hist_lut_ram_din)
   );
endmodule

// File: tb/tb_hist_lut_builder.sv
// Directed bench for hist_lut_builder: reset state, uniform/clip/spike LUTs,
// sweep timing, ignored starts and mid-sweep reset.
module tb_hist_lut_builder;
   import hist_eq_pkg::*;

   localparam int AW   = 14;
   localparam int BW   = 20;
   localparam int LW   = 8;
   localparam int CW   = 24;
   localparam int NB   = 1 << AW;
   localparam int COEF = 13056;   // round(255*2^24/327680), exact

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hist_lut_builder_if #(.ADDR_WIDTH(AW), .BIN_WIDTH(BW), .LUT_WIDTH(LW), .COEF_WIDTH(CW)) bus();

   hist_lut_builder #(
      .ADDR_WIDTH(AW), .BIN_WIDTH(BW), .LUT_WIDTH(LW),
      .COEF_WIDTH(CW), .FRAC_BITS(24), .RAM_LATENCY(2)
   ) dut (
      .axis_aclk   (clk),
      .axis_aresetn(rst_n),
      .bus         (bus)
   );

   // histogram RAM, two-cycle read latency; junk when not enabled
   logic [BW-1:0] hist_mem [NB];
   logic [BW-1:0] ram_r1;
   always @(posedge clk) begin
      ram_r1            <= bus.hist_ram_en ? hist_mem[bus.hist_ram_addr] : '1;
      bus.hist_ram_dout <= ram_r1;
   end

   int n_tests = 0;
   int n_fail  = 0;

   int wr_cnt, first_wr, last_wr, gap_cnt, addr_err;
   int rd_cnt, rd_err, done_cnt, done_rel, busy_cnt, busy_first, busy_last;
   logic [LW-1:0] lut_got [NB];

   function automatic logic [LW-1:0] exp_ramp(input int cnt, input int k);
      longint p;
      p = (longint'(cnt) * longint'(k + 1) * longint'(COEF)) >> 24;
      if (p > 255) p = 255;
      return 8'(p);
   endfunction

   task automatic fill_hist(input logic [BW-1:0] v);
      for (int i = 0; i < NB; i++) hist_mem[i] = v;
   endtask

   // Pulse start, then observe nrel cycles after it (rel = cycle index from start).
   task automatic run_sweep(input logic [CW-1:0] coef, input logic [BW-1:0] clip,
                            input bit poke_starts, input int nrel);
      int prev_wr;
      wr_cnt = 0; first_wr = -1; last_wr = -1; gap_cnt = 0; addr_err = 0;
      rd_cnt = 0; rd_err = 0; done_cnt = 0; done_rel = -1;
      busy_cnt = 0; busy_first = -1; busy_last = -1; prev_wr = -1;
      for (int i = 0; i < NB; i++) lut_got[i] = 8'hA5;
      @(negedge clk);
      bus.norm_coef  = coef;
      bus.clip_limit = clip;
      bus.start      = 1'b1;
      for (int rel = 1; rel <= nrel; rel++) begin
         @(negedge clk);
         bus.start      = 1'b0;
         bus.norm_coef  = ~coef;          // must not affect the running sweep
         bus.clip_limit = clip ^ 20'h5;
         if (bus.hist_ram_en === 1'b1) begin
            if (bus.hist_ram_addr !== AW'(rel - 1)) rd_err++;
            rd_cnt++;
         end
         if (bus.hist_lut_ram_we === 1'b1) begin
            if (wr_cnt == 0) first_wr = rel;
            else if (rel != prev_wr + 1) gap_cnt++;
            if (bus.hist_lut_ram_addr !== AW'(wr_cnt)) addr_err++;
            lut_got[bus.hist_lut_ram_addr] = bus.hist_lut_ram_din;
            prev_wr = rel;
            last_wr = rel;
            wr_cnt++;
         end
         if (bus.busy === 1'b1) begin
            if (busy_first < 0) busy_first = rel;
            busy_last = rel;
            busy_cnt++;
         end
         if (bus.done === 1'b1) begin
            done_cnt++;
            done_rel = rel;
            if (poke_starts) bus.start = 1'b1;
         end
         if (poke_starts && rel == 500) bus.start = 1'b1;
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic test_reset;
      bus.start = 1'b0; bus.norm_coef = '0; bus.clip_limit = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++; if (bus.busy !== 1'b0)            begin n_fail++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
      n_tests++; if (bus.done !== 1'b0)            begin n_fail++; $display("FAIL reset_done got %0b exp 0", bus.done); end
      n_tests++; if (bus.hist_ram_en !== 1'b0)     begin n_fail++; $display("FAIL reset_ram_en got %0b exp 0", bus.hist_ram_en); end
      n_tests++; if (bus.hist_lut_ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %0b exp 0", bus.hist_lut_ram_we); end
      n_tests++; if ({bus.hist_ram_addr, bus.hist_lut_ram_addr, bus.hist_lut_ram_din} !== '0) begin
         n_fail++; $display("FAIL reset_addr_din got %0h/%0h/%0h exp 0", bus.hist_ram_addr, bus.hist_lut_ram_addr, bus.hist_lut_ram_din);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_uniform_timing;
      int bad, fb, fg, fe;
      logic [LW-1:0] e;
      fill_hist(20'd20);
      run_sweep(CW'(COEF), '0, 1'b1, 16400);
      n_tests++; if (wr_cnt != NB)        begin n_fail++; $display("FAIL uni_wr_count got %0d exp %0d", wr_cnt, NB); end
      n_tests++; if (first_wr != 6)       begin n_fail++; $display("FAIL uni_first_write got %0d exp 6", first_wr); end
      n_tests++; if (last_wr != 16389)    begin n_fail++; $display("FAIL uni_last_write got %0d exp 16389", last_wr); end
      n_tests++; if (gap_cnt != 0)        begin n_fail++; $display("FAIL uni_write_gaps got %0d exp 0", gap_cnt); end
      n_tests++; if (addr_err != 0)       begin n_fail++; $display("FAIL uni_write_addr got %0d bad exp 0", addr_err); end
      n_tests++; if (rd_cnt != NB || rd_err != 0) begin n_fail++; $display("FAIL uni_reads got %0d reads %0d bad exp %0d reads 0 bad", rd_cnt, rd_err, NB); end
      n_tests++; if (done_cnt != 1 || done_rel != 16390) begin n_fail++; $display("FAIL uni_done got %0d pulses at %0d exp 1 at 16390", done_cnt, done_rel); end
      n_tests++; if (busy_first != 1 || busy_last != 16389 || busy_cnt != 16389) begin
         n_fail++; $display("FAIL uni_busy got %0d..%0d (%0d) exp 1..16389 (16389)", busy_first, busy_last, busy_cnt);
      end
      bad = 0; fb = -1; fg = 0; fe = 0;
      for (int k = 0; k < NB; k++) begin
         e = exp_ramp(20, k);
         if (lut_got[k] !== e) begin
            if (bad == 0) begin fb = k; fg = int'(lut_got[k]); fe = int'(e); end
            bad++;
         end
      end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL uni_lut %0d wrong, idx %0d got %0d exp %0d", bad, fb, fg, fe); end
      n_tests++; if (lut_got[NB-1] !== 8'd255) begin n_fail++; $display("FAIL uni_lut_last got %0d exp 255", lut_got[NB-1]); end
      n_tests++; if (lut_got[8191] !== 8'd127) begin n_fail++; $display("FAIL uni_lut_mid got %0d exp 127", lut_got[8191]); end
   endtask

   task automatic test_clip;
      int bad, fb, fg, fe;
      logic [LW-1:0] e;
      fill_hist(20'd50);
      run_sweep(CW'(COEF), 20'd10, 1'b0, 16395);
      n_tests++; if (wr_cnt != NB || done_cnt != 1) begin n_fail++; $display("FAIL clip_counts got %0d writes %0d done exp %0d 1", wr_cnt, done_cnt, NB); end
      bad = 0; fb = -1; fg = 0; fe = 0;
      for (int k = 0; k < NB; k++) begin
         e = exp_ramp(10, k);
         if (lut_got[k] !== e) begin
            if (bad == 0) begin fb = k; fg = int'(lut_got[k]); fe = int'(e); end
            bad++;
         end
      end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL clip_lut %0d wrong, idx %0d got %0d exp %0d", bad, fb, fg, fe); end
      n_tests++; if (lut_got[NB-1] !== 8'd127) begin n_fail++; $display("FAIL clip_lut_last got %0d exp 127", lut_got[NB-1]); end
   endtask

   task automatic test_mid_reset;
      int we_seen;
      fill_hist(20'd20);
      run_sweep(CW'(COEF), '0, 1'b0, 7999);
      n_tests++; if (wr_cnt != 7994) begin n_fail++; $display("FAIL mid_pre_writes got %0d exp 7994", wr_cnt); end
      // the bench is now in the second half of cycle 8000
      rst_n = 1'b0;
      #1;
      n_tests++; if ({bus.busy, bus.done, bus.hist_ram_en, bus.hist_lut_ram_we} !== 4'b0) begin
         n_fail++; $display("FAIL mid_rst_ctrl got %04b exp 0000", {bus.busy, bus.done, bus.hist_ram_en, bus.hist_lut_ram_we});
      end
      n_tests++; if ({bus.hist_ram_addr, bus.hist_lut_ram_addr, bus.hist_lut_ram_din} !== '0) begin
         n_fail++; $display("FAIL mid_rst_data got %0h/%0h/%0h exp 0", bus.hist_ram_addr, bus.hist_lut_ram_addr, bus.hist_lut_ram_din);
      end
      we_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.hist_lut_ram_we !== 1'b0) we_seen++;
      end
      n_tests++; if (we_seen != 0) begin n_fail++; $display("FAIL mid_rst_hold got %0d writes exp 0", we_seen); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_spike_after_reset;
      int bad, fb, fg, fe;
      logic [LW-1:0] e;
      fill_hist(20'd0);
      hist_mem[100] = 20'd327680;
      run_sweep(CW'(COEF), '0, 1'b0, 16395);
      n_tests++; if (wr_cnt != NB || done_rel != 16390) begin n_fail++; $display("FAIL spike_counts got %0d writes done at %0d exp %0d 16390", wr_cnt, done_rel, NB); end
      bad = 0; fb = -1; fg = 0; fe = 0;
      for (int k = 0; k < NB; k++) begin
         e = (k < 100) ? 8'd0 : 8'd255;
         if (lut_got[k] !== e) begin
            if (bad == 0) begin fb = k; fg = int'(lut_got[k]); fe = int'(e); end
            bad++;
         end
      end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL spike_lut %0d wrong, idx %0d got %0d exp %0d", bad, fb, fg, fe); end
      n_tests++; if (lut_got[99] !== 8'd0 || lut_got[100] !== 8'd255) begin
         n_fail++; $display("FAIL spike_edge got %0d/%0d exp 0/255", lut_got[99], lut_got[100]);
      end
   endtask

   initial begin
      test_reset;
      test_uniform_timing;
      test_clip;
      test_mid_reset;
      test_spike_after_reset;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
